// File: rtl/edge_period_ctrl.sv
// edge_period_ctrl: arms on start, spans N input periods, reports clk count.
// Optional 2-flop input synchronizer enabled by defining EDGE_PERIOD_SYNC_EN.
module edge_period_ctrl #(
    parameter int CNT_W  = 32,
    parameter int EDGE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    input  logic              start,
    input  logic [EDGE_W-1:0] n_edges,
    input  logic [CNT_W-1:0]  timeout,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              timed_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    logic              in_s;
    logic              in_q;
    logic              rise;
    logic [EDGE_W-1:0] n_lat;
    logic [CNT_W-1:0]  to_lat;
    logic [EDGE_W-1:0] edge_cnt;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  timer_next;
    logic [EDGE_W-1:0] edge_next;
    logic              to_hit;
    logic              last_edge;
    logic              count_max;

`ifdef EDGE_PERIOD_SYNC_EN
    logic [1:0] sync;

    // Two-stage synchronizer for an asynchronous measured input
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], in};
        end
    end

    assign in_s = sync[1];
`else
    assign in_s = in;
`endif

    // Previous input sample for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_s;
        end
    end

    assign rise       = in_s & ~in_q;
    assign timer_next = timer + 1'b1;
    assign edge_next  = edge_cnt + 1'b1;
    assign to_hit     = (to_lat != '0) && (timer_next == to_lat);
    assign last_edge  = rise && (edge_next == n_lat);
    assign count_max  = &count;

    // Sequencing FSM with registered busy/done/result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            timed_out <= 1'b0;
            n_lat     <= '0;
            to_lat    <= '0;
            edge_cnt  <= '0;
            timer     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_lat     <= (n_edges == '0) ?
                                     {{(EDGE_W-1){1'b0}}, 1'b1} : n_edges;
                        to_lat    <= timeout;
                        count     <= '0;
                        timed_out <= 1'b0;
                        edge_cnt  <= '0;
                        timer     <= '0;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    timer <= timer_next;
                    if (to_hit) begin
                        timed_out <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (rise) begin
                        count    <= '0;
                        edge_cnt <= '0;
                        state    <= MEAS;
                    end
                end
                MEAS: begin
                    timer <= timer_next;
                    if (!count_max) begin
                        count <= count + 1'b1;
                    end
                    if (last_edge) begin
                        timed_out <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (to_hit) begin
                        timed_out <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (rise) begin
                        edge_cnt <= edge_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_period_ctrl.sv
// tb_edge_period_ctrl: directed and randomized measurements against an
// event-level model of the input waveform (rise times, N-th rise, timeout).
module tb_edge_period_ctrl;

    localparam int CNT_W  = 32;
    localparam int EDGE_W = 8;
`ifdef EDGE_PERIOD_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in;
    logic              start;
    logic [EDGE_W-1:0] n_edges;
    logic [CNT_W-1:0]  timeout;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              timed_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gp = 0;
    int gh = 0;
    int gph = 0;
    bit wave [0:65535];

    edge_period_ctrl #(.CNT_W(CNT_W), .EDGE_W(EDGE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .start     (start),
        .n_edges   (n_edges),
        .timeout   (timeout),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .timed_out (timed_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Input waveform generator: period gp, high for gh, phase gph; gp=0 -> low
    function automatic bit gen_in(input int e);
        int m;
        if (gp == 0) return 1'b0;
        m = (e - gph) % gp;
        if (m < 0) m += gp;
        return m < gh;
    endfunction

    function automatic bit w(input int e);
        if (e < 0) return 1'b0;
        if (e <= cyc) return wave[e];
        return gen_in(e);
    endfunction

    function automatic bit rise_at(input int e);
        return w(e - D) && !w(e - D - 1);
    endfunction

    // One clock: input value for edge cyc+1 is recorded, outputs read #1 later
    task automatic tick();
        in = gen_in(cyc + 1);
        wave[cyc + 1] = in;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    // Start accepted at edge k: predict the edge after which done is visible
    task automatic model(input int k, input int n, input int t,
                         output int de, output int dc, output bit dto,
                         output bit ok);
        int t0;
        int hits;
        int nn;
        nn = (n == 0) ? 1 : n;
        t0 = -1;
        hits = 0;
        ok = 1'b0;
        de = 0;
        dc = 0;
        dto = 1'b0;
        for (int e = k + 1; e <= k + 4000 && !ok; e++) begin
            if (t0 < 0) begin
                if (t != 0 && e == k + t) begin
                    ok = 1'b1; de = e; dc = 0; dto = 1'b1;
                end else if (rise_at(e)) begin
                    t0 = e;
                end
            end else begin
                if (rise_at(e)) hits++;
                if (hits == nn) begin
                    ok = 1'b1; de = e; dc = e - t0; dto = 1'b0;
                end else if (t != 0 && e == k + t) begin
                    ok = 1'b1; de = e; dc = e - t0; dto = 1'b1;
                end
            end
        end
    endtask

    task automatic run(input string tag, input int n, input int t,
                       input bit spam);
        int k;
        int de;
        int dc;
        bit dto;
        bit ok;
        bit bad;
        k = cyc + 1;
        model(k, n, t, de, dc, dto, ok);
        start = 1'b1;
        n_edges = EDGE_W'(n);
        timeout = CNT_W'(t);
        tick();
        start = 1'b0;
        bad = 1'b0;
        if (!ok) begin
            for (int i = 0; i < 200; i++) begin
                if (!(busy === 1'b1 && done === 1'b0)) bad = 1'b1;
                tick();
            end
            chk({tag, ".busy_hold"}, 64'(bad), 64'd0);
            return;
        end
        while (cyc < de) begin
            if (!(busy === 1'b1 && done === 1'b0)) bad = 1'b1;
            if (spam) begin
                start = 1'($urandom % 2);
                n_edges = EDGE_W'($urandom);
                timeout = CNT_W'($urandom);
            end
            tick();
        end
        chk({tag, ".busy_window"}, 64'(bad), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, ".count"}, 64'(count), 64'(dc));
        chk({tag, ".timed_out"}, 64'(timed_out), 64'(dto));
        if (spam) start = 1'($urandom % 2);
        tick();
        start = 1'b0;
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".count_hold"}, 64'(count), 64'(dc));
        chk({tag, ".busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".count"}, 64'(count), 64'd0);
        chk({tag, ".timed_out"}, 64'(timed_out), 64'd0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic set_gen(input int p, input int h, input int ph);
        gp = p;
        gh = h;
        gph = ph;
    endtask

    initial begin
        int k;
        int de;
        int dc;
        bit dto;
        bit ok;
        int p;
        reset = 1'b1;
        in = 1'b0;
        start = 1'b0;
        n_edges = '0;
        timeout = '0;
        set_gen(0, 0, 0);
        tick();
        tick();
        do_reset("reset0");

        set_gen(10, 5, 3);
        tick();
        run("p10_n1", 1, 0, 1'b0);

        set_gen(7, 3, 1);
        run("p7_n4", 4, 0, 1'b0);
        run("p7_n0", 0, 0, 1'b0);
        run("b2b", 2, 0, 1'b0);

        set_gen(0, 0, 0);
        tick();
        tick();
        run("stuck_t50", 1, 50, 1'b0);
        run("stuck_t1", 3, 1, 1'b0);
        run("stuck_t0", 1, 0, 1'b0);
        do_reset("reset_arm");

        set_gen(10, 4, 6);
        tick();
        k = cyc + 1;
        model(k, 2, 0, de, dc, dto, ok);
        run("tie", 2, de - k, 1'b0);
        k = cyc + 1;
        model(k, 3, 0, de, dc, dto, ok);
        run("early_to", 3, de - k - 1, 1'b0);
        run("spam", 3, 0, 1'b1);

        start = 1'b1;
        n_edges = 8'd5;
        timeout = '0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_meas.busy", 64'(busy), 64'd1);
        do_reset("reset_meas");
        run("after_reset", 2, 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            p = $urandom_range(20, 2);
            set_gen(p, $urandom_range(p - 1, 1), $urandom_range(p - 1, 0));
            tick();
            tick();
            run($sformatf("rnd%0d", r), $urandom_range(6, 0),
                ($urandom % 2) ? $urandom_range(120, 1) : 0,
                1'($urandom % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
